izh_param_loader: RTL and testbench

IZH_PARAM_LOADER -- requirements
Module: izh_param_loader

---
 rtl/izh_pkg.sv | 24 ++
 rtl/izh_param_loader.sv | 173 +++++++++++++++++
 tb/tb_izh_param_loader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/izh_pkg.sv
// ============================================================================
// Module      : izh_pkg
// Description : Shared types and constants for the Izhikevich parameter loader.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package izh_pkg;

    localparam int         PARAM_W          = 12;
    localparam int         FRAME_DATA_BYTES = 6;
    localparam int         SHADOW_W         = 4 * PARAM_W;
    localparam logic [7:0] DEFAULT_HEADER   = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RX     = 2'd1,
        ST_CHK    = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/izh_param_loader.sv
// ============================================================================
// Module      : izh_param_loader
// Description : Byte-serial loader for four signed 12-bit neuron parameters,
//               committed atomically. Define IZH_PARAM_CKSUM_EN for a trailing
//               XOR checksum byte.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module izh_param_loader
    import izh_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [7:0] HEADER         = DEFAULT_HEADER
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid,
    output logic                      byte_ready,
    output logic signed [PARAM_W-1:0] param_a,
    output logic signed [PARAM_W-1:0] param_b,
    output logic signed [PARAM_W-1:0] param_c,
    output logic signed [PARAM_W-1:0] param_d,
    output logic                      params_ready,
    output logic                      param_update,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int TMR_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       LAST_BYTE = 3'(FRAME_DATA_BYTES - 1);

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [SHADOW_W-1:0] shadow_q, shadow_d;
    logic [SHADOW_W-1:0] params_q, params_d;
    logic                params_ready_q, params_ready_d;
    logic                param_update_q, param_update_d;
    logic                frame_err_q, frame_err_d;
`ifdef IZH_PARAM_CKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic accept;

    assign byte_ready = (state_q != ST_COMMIT) && !reset;
    assign accept     = byte_valid && byte_ready;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        timer_d        = timer_q;
        shadow_d       = shadow_q;
        params_d       = params_q;
        params_ready_d = params_ready_q;
        param_update_d = 1'b0;
        frame_err_d    = 1'b0;
`ifdef IZH_PARAM_CKSUM_EN
        csum_d         = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept && (byte_in == HEADER)) begin
                    state_d = ST_RX;
                    cnt_d   = '0;
                    timer_d = '0;
`ifdef IZH_PARAM_CKSUM_EN
                    csum_d  = '0;
`endif
                end
            end

            ST_RX: begin
                if (accept) begin
                    shadow_d = {shadow_q[SHADOW_W-9:0], byte_in};
                    timer_d  = '0;
`ifdef IZH_PARAM_CKSUM_EN
                    csum_d   = csum_q ^ byte_in;
`endif
                    if (cnt_q == LAST_BYTE) begin
`ifdef IZH_PARAM_CKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_COMMIT;
`endif
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (timer_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

`ifdef IZH_PARAM_CKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    timer_d = '0;
                    if (byte_in == csum_q) begin
                        state_d = ST_COMMIT;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else if (timer_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
`endif

            ST_COMMIT: begin
                // All four parameters move together so the neuron never sees a mixed set
                params_d       = shadow_q;
                params_ready_d = 1'b1;
                param_update_d = 1'b1;
                state_d        = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            timer_q        <= '0;
            shadow_q       <= '0;
            params_q       <= '0;
            params_ready_q <= 1'b0;
            param_update_q <= 1'b0;
            frame_err_q    <= 1'b0;
`ifdef IZH_PARAM_CKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            timer_q        <= timer_d;
            shadow_q       <= shadow_d;
            params_q       <= params_d;
            params_ready_q <= params_ready_d;
            param_update_q <= param_update_d;
            frame_err_q    <= frame_err_d;
`ifdef IZH_PARAM_CKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign param_a      = params_q[4*PARAM_W-1 -: PARAM_W];
    assign param_b      = params_q[3*PARAM_W-1 -: PARAM_W];
    assign param_c      = params_q[2*PARAM_W-1 -: PARAM_W];
    assign param_d      = params_q[PARAM_W-1   -: PARAM_W];
    assign params_ready = params_ready_q;
    assign param_update = param_update_q;
    assign frame_err    = frame_err_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_izh_param_loader.sv
// ============================================================================
// Module      : tb_izh_param_loader
// Description : Self-checking bench for izh_param_loader (table vectors, corner
//               sequences, randomized stream against a frame-level model).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_izh_param_loader;

    localparam int         TMO = 255;
    localparam logic [7:0] HDR = 8'hA5;
`ifdef IZH_PARAM_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int BODY = CK ? 7 : 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic signed [11:0] param_a, param_b, param_c, param_d;
    logic              params_ready, param_update, frame_err, busy;

    always #5 clk = ~clk;

    izh_param_loader #(
        .TIMEOUT_CYCLES(TMO),
        .HEADER        (HDR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .param_a     (param_a),
        .param_b     (param_b),
        .param_c     (param_c),
        .param_d     (param_d),
        .params_ready(params_ready),
        .param_update(param_update),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [47:0] data;
        logic [7:0]  ck;
        int          ea, eb, ec, ed;
        bit          ok;
    } vec_t;
    vec_t tbl [6];

    int cur_a = 0, cur_b = 0, cur_c = 0, cur_d = 0, cur_ready = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        bit acc;
        guard = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        do begin
            acc = byte_ready;
            tick();
            guard++;
        end while (!acc && guard < 20);
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_byte: byte %h never accepted, expected acceptance within 20 cycles", b);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit hold);
        bit ok;
        ok = v.ok || !CK;
        send_byte(HDR);
        for (int i = 0; i < 6; i++) send_byte(v.data[47-8*i -: 8]);
        if (CK) send_byte(v.ck);
        if (hold) begin
            byte_valid = 1'b1;
            byte_in    = 8'h77;
        end else begin
            byte_valid = 1'b0;
        end
        chk("ready_after_last", int'(byte_ready), ok ? 0 : 1);
        chk("err_cycle1", int'(frame_err), ok ? 0 : 1);
        chk("upd_cycle1", int'(param_update), 0);
        if (ok) begin
            cur_a = v.ea; cur_b = v.eb; cur_c = v.ec; cur_d = v.ed; cur_ready = 1;
        end
        tick();
        byte_valid = 1'b0;
        chk("upd_cycle2", int'(param_update), ok ? 1 : 0);
        chk("err_cycle2", int'(frame_err), 0);
        chk("param_a", int'(param_a), cur_a);
        chk("param_b", int'(param_b), cur_b);
        chk("param_c", int'(param_c), cur_c);
        chk("param_d", int'(param_d), cur_d);
        chk("params_ready", int'(params_ready), cur_ready);
    endtask

    // Frame-level reference model
    bit         m_in, m_pend, m_rdy, m_upd, m_err;
    logic [7:0] m_q[$];
    int         m_idle, m_a, m_b, m_c, m_d;

    function automatic int sx12(input logic [11:0] x);
        return (x >= 12'h800) ? int'(x) - 4096 : int'(x);
    endfunction

    task automatic model_reset();
        m_in = 0; m_pend = 0; m_rdy = 0; m_upd = 0; m_err = 0;
        m_q.delete(); m_idle = 0; m_a = 0; m_b = 0; m_c = 0; m_d = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b);
        logic [47:0] w;
        logic [7:0]  x;
        m_upd = 0;
        m_err = 0;
        if (m_pend) begin
            w = '0;
            for (int i = 0; i < 6; i++) w = (w << 8) | 48'(m_q[i]);
            m_a = sx12(w[47:36]); m_b = sx12(w[35:24]);
            m_c = sx12(w[23:12]); m_d = sx12(w[11:0]);
            m_rdy = 1; m_upd = 1; m_pend = 0;
        end else if (m_in) begin
            if (v) begin
                m_q.push_back(b);
                m_idle = 0;
                if (m_q.size() == BODY) begin
                    m_in = 0;
                    x = '0;
                    for (int i = 0; i < 6; i++) x ^= m_q[i];
                    if (CK && (x != m_q[BODY-1])) m_err = 1;
                    else m_pend = 1;
                end
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_err = 1;
                    m_in  = 0;
                end
            end
        end else if (v && b == HDR) begin
            m_in = 1;
            m_q.delete();
            m_idle = 0;
        end
    endtask

    logic [7:0] sq[$];
    int         gap;

    task automatic gen_chunk();
        int         r;
        logic [7:0] x, b;
        r   = $urandom_range(99);
        gap = $urandom_range(3);
        if (r < 70) begin
            sq.push_back(HDR);
            x = '0;
            for (int i = 0; i < 6; i++) begin
                b = 8'($urandom);
                x ^= b;
                sq.push_back(b);
            end
            if (CK) sq.push_back((r < 55) ? x : (x ^ 8'($urandom_range(1, 255))));
        end else if (r < 85) begin
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                b = 8'($urandom);
                sq.push_back((b == HDR) ? 8'h5A : b);
            end
        end else begin
            sq.push_back(HDR);
            for (int i = 0; i < int'($urandom_range(1, 5)); i++) sq.push_back(8'($urandom));
            gap = TMO + int'($urandom_range(1, 10));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        bit   v, rdy_pre, err_seen;
        int   k;

        tbl[0] = '{data: 48'h005033980002, ck: 8'hF9, ea: 5,     eb: 51,    ec: -1664, ed: 2,     ok: 1};
        tbl[1] = '{data: 48'h005033980002, ck: 8'h00, ea: 5,     eb: 51,    ec: -1664, ed: 2,     ok: 0};
        tbl[2] = '{data: 48'hFFF8007FF800, ck: 8'h80, ea: -1,    eb: -2048, ec: 2047,  ed: -2048, ok: 1};
        tbl[3] = '{data: 48'hA5A5A5A5A5A5, ck: 8'h00, ea: -1446, eb: 1445,  ec: -1446, ed: 1445,  ok: 1};
        tbl[4] = '{data: 48'h123456789ABC, ck: 8'h2E, ea: 291,   eb: 1110,  ec: 1929,  ed: -1348, ok: 1};
        tbl[5] = '{data: 48'h000000000001, ck: 8'h00, ea: 0,     eb: 0,     ec: 0,     ed: 1,     ok: 0};

        reset = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
        tick(); tick();
        chk("ready_in_reset", int'(byte_ready), 0);
        reset = 1'b0;
        #1;
        chk("rst_ready", int'(byte_ready), 1);
        chk("rst_a", int'(param_a), 0);
        chk("rst_d", int'(param_d), 0);
        chk("rst_params_ready", int'(params_ready), 0);
        chk("rst_upd", int'(param_update), 0);
        chk("rst_err", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);

        // Bad-checksum frame first: params stay zero and not ready
        run_vec(tbl[1], 1'b0);
        for (int i = 0; i < 6; i++) run_vec(tbl[i], 1'b0);

        // Junk before header, header inside data, valid held during commit
        send_byte(8'h12);
        byte_valid = 1'b0;
        chk("junk_busy", int'(busy), 0);
        chk("junk_err", int'(frame_err), 0);
        run_vec(tbl[3], 1'b1);

        // Timeout after a partial frame
        send_byte(HDR); send_byte(8'h00); send_byte(8'h50);
        byte_valid = 1'b0;
        k = 0;
        while (!frame_err && k < 400) begin
            tick();
            k++;
        end
        chk("tmo_cycles", k, TMO);
        chk("tmo_params_kept", int'(param_a), cur_a);
        chk("tmo_ready_kept", int'(params_ready), cur_ready);
        tick();
        chk("tmo_err_pulse_len", int'(frame_err), 0);
        chk("tmo_busy", int'(busy), 0);
        run_vec(tbl[0], 1'b0);

        // Reset in the middle of a frame
        send_byte(HDR); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        byte_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_ready", int'(byte_ready), 0);
        err_seen = 0;
        tick(); err_seen |= frame_err;
        tick(); err_seen |= frame_err;
        reset = 1'b0;
        #1;
        chk("midrst_a", int'(param_a), 0);
        chk("midrst_c", int'(param_c), 0);
        chk("midrst_params_ready", int'(params_ready), 0);
        chk("midrst_busy", int'(busy), 0);
        tick(); err_seen |= frame_err;
        chk("midrst_no_err", int'(err_seen), 0);
        cur_a = 0; cur_b = 0; cur_c = 0; cur_d = 0; cur_ready = 0;

        // Randomized stream against the frame-level model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        sq.delete();
        gap = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (sq.size() == 0) begin
                if (gap > 0) gap--;
                else gen_chunk();
            end
            v = (sq.size() != 0) && ($urandom_range(3) != 0);
            byte_valid = v;
            byte_in    = v ? sq[0] : 8'($urandom);
            rdy_pre    = !m_pend;
            @(posedge clk);
            model_step(v, byte_in);
            if (v && rdy_pre) void'(sq.pop_front());
            #1;
            chk("rnd_ready", int'(byte_ready), int'(!m_pend));
            chk("rnd_busy", int'(busy), int'(m_in || m_pend));
            chk("rnd_upd", int'(param_update), int'(m_upd));
            chk("rnd_err", int'(frame_err), int'(m_err));
            chk("rnd_params_ready", int'(params_ready), int'(m_rdy));
            chk("rnd_a", int'(param_a), m_a);
            chk("rnd_b", int'(param_b), m_b);
            chk("rnd_c", int'(param_c), m_c);
            chk("rnd_d", int'(param_d), m_d);
        end
        byte_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
